conv_bitserial_seq: RTL and testbench

//   Bit-serial sequencer for the conv_lut_bitsab 4-input LUT.
//   - Accepts four unsigned activation words and presents them LSB-first, one bit-plane per cycle, on the LUT inputs.
//   - Accumulates the returned 2-bit LUT value, weighted by 2^k, into one result.
//   - Sits between the activation buffer and the kernel output adder tree; one instance per LUT.

---
 rtl/conv_bitserial_seq.sv | 104 ++++++++++
 tb/tb_conv_bitserial_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_bitserial_seq.sv
// Bit-serial sequencer for a 4-input, 2-bit-output LUT. It streams four activation
// words LSB-first into the LUT and sums the returned values, weighting each by 2^k.
module conv_bitserial_seq #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   act_1,
    input  logic [DATA_W-1:0]   act_2,
    input  logic [DATA_W-1:0]   act_3,
    input  logic [DATA_W-1:0]   act_4,
    output logic                lut_bit1,
    output logic                lut_bit2,
    output logic                lut_bit3,
    output logic                lut_bit4,
    input  logic                lut_dout1,
    input  logic                lut_dout2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W+1:0]   result,
    output logic                busy
);

    localparam int ACC_W = DATA_W + 2;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state;
    logic [3:0][DATA_W-1:0]  sr;
    logic [CNT_W-1:0]        cnt;
    logic [ACC_W-1:0]        acc;
    logic [3:0]              lut_bits;
    logic                    last;
    logic [ACC_W-1:0]        term;

    assign last = (cnt == CNT_W'(DATA_W - 1));
    assign term = ACC_W'({lut_dout2, lut_dout1}) << cnt;

    // lut_bits is its own register so the LUT inputs never glitch; it always holds
    // the bit-plane the accumulator will sample on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            acc      <= '0;
            lut_bits <= '0;
        end else if (clear) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            acc      <= '0;
            lut_bits <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr       <= {act_4, act_3, act_2, act_1};
                        lut_bits <= {act_4[0], act_3[0], act_2[0], act_1[0]};
                        cnt      <= '0;
                        acc      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc + term;
                    for (int i = 0; i < 4; i++) begin
                        sr[i] <= sr[i] >> 1;
                    end
                    if (last) begin
                        cnt      <= '0;
                        lut_bits <= '0;
                        state    <= DONE;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        lut_bits <= {sr[3][1], sr[2][1], sr[1][1], sr[0][1]};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = acc;
    assign lut_bit1  = lut_bits[0];
    assign lut_bit2  = lut_bits[1];
    assign lut_bit3  = lut_bits[2];
    assign lut_bit4  = lut_bits[3];

endmodule

// File: tb/tb_conv_bitserial_seq.sv
// Directed bench for conv_bitserial_seq: a behavioural LUT with selectable mapping
// feeds the sequencer, and hand-computed sums are checked with immediate assertions.
module tb_conv_bitserial_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] act_1, act_2, act_3, act_4;
    logic       lut_bit1, lut_bit2, lut_bit3, lut_bit4;
    logic       lut_dout1, lut_dout2;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] result;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int lut_mode = 0;
    int seen_valid;

    conv_bitserial_seq #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act_1     (act_1),
        .act_2     (act_2),
        .act_3     (act_3),
        .act_4     (act_4),
        .lut_bit1  (lut_bit1),
        .lut_bit2  (lut_bit2),
        .lut_bit3  (lut_bit3),
        .lut_bit4  (lut_bit4),
        .lut_dout1 (lut_dout1),
        .lut_dout2 (lut_dout2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Mode 0 stands in for the real LUT on the first vector: 2*bit_1.
    always_comb begin
        {lut_dout2, lut_dout1} = 2'b00;
        case (lut_mode)
            0: {lut_dout2, lut_dout1} = {lut_bit1, 1'b0};
            1: {lut_dout2, lut_dout1} = {lut_bit4, lut_bit3};
            2: {lut_dout2, lut_dout1} = {lut_bit2, lut_bit1};
            default: {lut_dout2, lut_dout1} = 2'b00;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a1, input logic [7:0] a2,
                                 input logic [7:0] a3, input logic [7:0] a4);
        @(negedge clk);
        act_1 = a1; act_2 = a2; act_3 = a3; act_4 = a4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [7:0] a1, input logic [7:0] a2,
                         input logic [7:0] a3, input logic [7:0] a4,
                         input logic [9:0] exp, input int hold);
        applyStimulus(a1, a2, a3, a4);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            checkOutput({tag, "_bits"}, 32'({lut_bit4, lut_bit3, lut_bit2, lut_bit1}),
                        32'({a4[k], a3[k], a2[k], a1[k]}));
            if (k == 0 || k == 7) begin
                checkOutput({tag, "_run_ready"}, 32'(in_ready), 32'd0);
                checkOutput({tag, "_run_valid"}, 32'(out_valid), 32'd0);
            end
            @(posedge clk); #1;
        end
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_result"}, 32'(result), 32'(exp));
        checkOutput({tag, "_done_bits"}, 32'({lut_bit4, lut_bit3, lut_bit2, lut_bit1}), 32'd0);
        checkOutput({tag, "_done_ready"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_hold_result"}, 32'(result), 32'(exp));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_taken_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_taken_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_taken_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        act_1 = '0; act_2 = '0; act_3 = '0; act_4 = '0;
        #12;
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_bits", 32'({lut_bit4, lut_bit3, lut_bit2, lut_bit1}), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic 2*act_1");
        lut_mode = 0;
        runOp("t1", 8'hA5, 8'hFF, 8'hFF, 8'hFF, 10'h14A, 0);

        $display("[TB] act_3 + 2*act_4");
        lut_mode = 1;
        runOp("t2", 8'h00, 8'h00, 8'h0F, 8'hF0, 10'h1EF, 0);

        $display("[TB] max value with held output");
        runOp("t3", 8'h00, 8'h00, 8'hFF, 8'hFF, 10'h2FD, 5);

        $display("[TB] back-to-back");
        lut_mode = 2;
        @(negedge clk);
        act_1 = 8'h3C; act_2 = 8'h81; act_3 = 8'h00; act_4 = 8'h00;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        act_1 = 8'hFF; act_2 = 8'h01;
        checkOutput("b2b_first_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("b2b_run_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        checkOutput("b2b_first_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_first_result", 32'(result), 32'h13E);
        checkOutput("b2b_done_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("b2b_gap_valid", 32'(out_valid), 32'd0);
        checkOutput("b2b_gap_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("b2b_second_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
        end
        checkOutput("b2b_second_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_second_result", 32'(result), 32'h101);
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("b2b_second_taken", 32'(out_valid), 32'd0);

        $display("[TB] clear mid-run");
        lut_mode = 1;
        applyStimulus(8'h00, 8'h00, 8'hFF, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        clear = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        checkOutput("clr_busy", 32'(busy), 32'd0);
        checkOutput("clr_ready", 32'(in_ready), 32'd1);
        checkOutput("clr_result", 32'(result), 32'd0);
        checkOutput("clr_bits", 32'({lut_bit4, lut_bit3, lut_bit2, lut_bit1}), 32'd0);
        seen_valid = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        checkOutput("clr_no_valid", 32'(seen_valid), 32'd0);
        runOp("t5", 8'h00, 8'h00, 8'h12, 8'h34, 10'h07A, 0);

        $display("[TB] async reset mid-run");
        lut_mode = 2;
        applyStimulus(8'hFF, 8'hFF, 8'h00, 8'h00);
        @(posedge clk); #4;
        rst = 1'b1;
        #1;
        checkOutput("arst_ready", 32'(in_ready), 32'd1);
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_result", 32'(result), 32'd0);
        checkOutput("arst_bits", 32'({lut_bit4, lut_bit3, lut_bit2, lut_bit1}), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        runOp("t6", 8'h55, 8'hAA, 8'h00, 8'h00, 10'h1A9, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
